// File: rtl/reg_xfer_ctrl.sv
// Initiator for the 8x16 register bank: single-register READ/WRITE/MOVE plus whole-bank SAVE/RESTORE streams.
// Define RXC_ZERO_REG_EN to treat r0 as a hardwired zero register. i_reset is asynchronous and active-low.
module reg_xfer_ctrl #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [2:0]               i_cmd_op,
    input  logic [$clog2(NREG)-1:0]  i_cmd_src,
    input  logic [$clog2(NREG)-1:0]  i_cmd_dst,
    input  logic [DW-1:0]            i_cmd_data,
    output logic                     o_rsp_valid,
    output logic                     o_rsp_err,
    output logic [DW-1:0]            o_rsp_data,
    output logic                     o_busy,
    output logic                     o_sv_valid,
    input  logic                     i_sv_ready,
    output logic [DW-1:0]            o_sv_data,
    input  logic                     i_rs_valid,
    output logic                     o_rs_ready,
    input  logic [DW-1:0]            i_rs_data,
    output logic [$clog2(NREG)-1:0]  o_rb_id,
    output logic [DW-1:0]            o_rb_din,
    output logic                     o_rb_ld,
    input  logic [DW-1:0]            i_rb_dout
);

    localparam int IW = $clog2(NREG);
    localparam logic [IW-1:0] LAST = IW'(NREG - 1);

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_READ    = 3'b001;
    localparam logic [2:0] OP_WRITE   = 3'b010;
    localparam logic [2:0] OP_MOVE    = 3'b011;
    localparam logic [2:0] OP_SAVE    = 3'b100;
    localparam logic [2:0] OP_RESTORE = 3'b101;

`ifdef RXC_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_MV_RD,
        S_MV_WR,
        S_SV_RD,
        S_SV_OUT,
        S_RS_WAIT,
        S_RS_WR
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_dst;
    logic [IW-1:0]   r_rb_id;
    logic [DW-1:0]   r_rb_din;
    logic            r_rb_ld;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [DW-1:0]   r_rsp_data;
    logic            r_sv_valid;
    logic [DW-1:0]   r_sv_data;
    logic            r_rs_ready;

    logic [DW-1:0]   w_rd_word;
    logic            w_cmd_dst_ld;
    logic            w_mv_dst_ld;
    logic            w_rs_ld;

    // Every bank read is addressed by r_rb_id, so masking r0 here covers READ, MOVE and SAVE alike.
    assign w_rd_word    = (ZERO_REG && (r_rb_id == '0)) ? '0 : i_rb_dout;
    assign w_cmd_dst_ld = !(ZERO_REG && (i_cmd_dst == '0));
    assign w_mv_dst_ld  = !(ZERO_REG && (r_dst == '0));
    assign w_rs_ld      = !(ZERO_REG && (r_idx == '0));

    assign o_cmd_ready = (r_state == S_IDLE) && i_reset;
    assign o_busy      = (r_state != S_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_data  = r_rsp_data;
    assign o_sv_valid  = r_sv_valid;
    assign o_sv_data   = r_sv_data;
    assign o_rs_ready  = r_rs_ready;
    assign o_rb_id     = r_rb_id;
    assign o_rb_din    = r_rb_din;
    assign o_rb_ld     = r_rb_ld;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_dst       <= '0;
            r_rb_id     <= '0;
            r_rb_din    <= '0;
            r_rb_ld     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_sv_valid  <= 1'b0;
            r_sv_data   <= '0;
            r_rs_ready  <= 1'b0;
        end else begin
            // Pulses default low so rb_ld and rsp_valid never last longer than one cycle.
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rb_ld     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_dst <= i_cmd_dst;
                        case (i_cmd_op)
                            OP_NOP: r_rsp_valid <= 1'b1;
                            OP_READ: begin
                                r_rb_id <= i_cmd_src;
                                r_state <= S_RD;
                            end
                            OP_WRITE: begin
                                r_rb_id  <= i_cmd_dst;
                                r_rb_din <= i_cmd_data;
                                r_rb_ld  <= w_cmd_dst_ld;
                                r_state  <= S_WR;
                            end
                            OP_MOVE: begin
                                r_rb_id <= i_cmd_src;
                                r_state <= S_MV_RD;
                            end
                            OP_SAVE: begin
                                r_idx   <= '0;
                                r_rb_id <= '0;
                                r_state <= S_SV_RD;
                            end
                            OP_RESTORE: begin
                                r_idx      <= LAST;
                                r_rs_ready <= 1'b1;
                                r_state    <= S_RS_WAIT;
                            end
                            default: begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD: begin
                    r_rsp_data  <= w_rd_word;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_MV_RD: begin
                    r_rb_din <= w_rd_word;
                    r_rb_id  <= r_dst;
                    r_rb_ld  <= w_mv_dst_ld;
                    r_state  <= S_MV_WR;
                end
                S_MV_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_SV_RD: begin
                    r_sv_data  <= w_rd_word;
                    r_sv_valid <= 1'b1;
                    r_state    <= S_SV_OUT;
                end
                S_SV_OUT: begin
                    if (i_sv_ready) begin
                        r_sv_valid <= 1'b0;
                        if (r_idx == LAST) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_rb_id <= r_idx + IW'(1);
                            r_state <= S_SV_RD;
                        end
                    end
                end
                // Restore fills r7 down to r0 so a SAVE stream popped off a stack lands back in place.
                S_RS_WAIT: begin
                    if (i_rs_valid) begin
                        r_rb_din   <= i_rs_data;
                        r_rb_id    <= r_idx;
                        r_rb_ld    <= w_rs_ld;
                        r_rs_ready <= 1'b0;
                        r_state    <= S_RS_WR;
                    end
                end
                S_RS_WR: begin
                    if (r_idx == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_idx      <= r_idx - IW'(1);
                        r_rs_ready <= 1'b1;
                        r_state    <= S_RS_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Scoreboard bench for reg_xfer_ctrl: a behavioural 8x16 bank, queued response expectations and stream monitors.
// Builds with or without RXC_ZERO_REG_EN; the zero-register expectations follow the macro.
module tb_reg_xfer_ctrl;

    localparam int DW = 16;
`ifdef RXC_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_READ    = 3'b001;
    localparam logic [2:0] OP_WRITE   = 3'b010;
    localparam logic [2:0] OP_MOVE    = 3'b011;
    localparam logic [2:0] OP_SAVE    = 3'b100;
    localparam logic [2:0] OP_RESTORE = 3'b101;

    logic          clk = 1'b0;
    logic          rstN;
    logic          cmdValid, cmdReady;
    logic [2:0]    cmdOp, cmdSrc, cmdDst;
    logic [DW-1:0] cmdData;
    logic          rspValid, rspErr;
    logic [DW-1:0] rspData;
    logic          busy;
    logic          svValid, svReady;
    logic [DW-1:0] svData;
    logic          rsValid, rsReady;
    logic [DW-1:0] rsData;
    logic [2:0]    rbId;
    logic [DW-1:0] rbDin;
    logic          rbLd;
    logic [DW-1:0] rbDout;

    always #5 clk = ~clk;

    reg_xfer_ctrl #(.DW(DW), .NREG(8)) dut (
        .i_clk(clk), .i_reset(rstN),
        .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd_op(cmdOp),
        .i_cmd_src(cmdSrc), .i_cmd_dst(cmdDst), .i_cmd_data(cmdData),
        .o_rsp_valid(rspValid), .o_rsp_err(rspErr), .o_rsp_data(rspData), .o_busy(busy),
        .o_sv_valid(svValid), .i_sv_ready(svReady), .o_sv_data(svData),
        .i_rs_valid(rsValid), .o_rs_ready(rsReady), .i_rs_data(rsData),
        .o_rb_id(rbId), .o_rb_din(rbDin), .o_rb_ld(rbLd), .i_rb_dout(rbDout)
    );

    // Behavioural register bank: load gated by clk, read combinational on the id.
    logic [DW-1:0] bank [8];
    always @(posedge clk) if (rbLd) bank[rbId] <= rbDin;
    assign rbDout = bank[rbId];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void failNow(string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endfunction

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          expTab [128];
    int            expTail = 0;
    int            expHead = 0;
    logic [DW-1:0] mBank [8];
    logic [DW-1:0] mRsp;

    function automatic logic [DW-1:0] svExp(int i);
        return (ZERO && i == 0) ? '0 : mBank[i];
    endfunction

    // Response monitor: pops one expectation per rsp_valid pulse.
    always @(negedge clk) begin
        if (rstN && rspValid) begin
            if (expHead == expTail) begin
                failNow("rsp_unexpected");
            end else begin
                checkOutput("rsp_err", {31'd0, rspErr}, {31'd0, expTab[expHead].err});
                checkOutput("rsp_data", {16'd0, rspData}, {16'd0, expTab[expHead].data});
                if (expTab[expHead].cyc >= 0)
                    checkOutput("rsp_cycle", cyc, expTab[expHead].cyc);
                expHead++;
            end
        end
    end

    // SAVE stream monitor: words must arrive r0 first and stay put while stalled.
    int svIdx = 0;
    int svTotal = 0;
    always @(negedge clk) begin
        if (!rstN) begin
            svIdx = 0;
        end else if (svValid) begin
            if (svReady) begin
                checkOutput("sv_word", {16'd0, svData}, {16'd0, svExp(svIdx)});
                svIdx = (svIdx + 1) % 8;
                svTotal++;
            end else begin
                checkOutput("sv_hold", {16'd0, svData}, {16'd0, svExp(svIdx)});
            end
        end
    end

    int            ldCount = 0;
    logic [2:0]    lastId;
    logic [DW-1:0] lastDin;
    always @(negedge clk) begin
        if (rstN && rbLd) begin
            ldCount++;
            lastId  = rbId;
            lastDin = rbDin;
        end
    end

    int svMode = 0;
    int svPhase = 0;
    initial begin
        svReady = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (svMode)
                0:       svReady = 1'b1;
                1:       svReady = (svPhase % 3 == 0);
                default: svReady = 1'b0;
            endcase
            svPhase++;
        end
    end

    // RESTORE source: words 0xA7 down to 0xA0 with a bubble every third cycle.
    bit rsEnable = 1'b0;
    int rsIdx = 0;
    int rsPhase = 0;
    initial begin
        bit hs;
        rsValid = 1'b0;
        rsData  = '0;
        forever begin
            @(negedge clk);
            hs = rsValid && rsReady;
            @(posedge clk); #1;
            if (!rsEnable) rsIdx = 0;
            else if (hs) rsIdx++;
            rsValid = rsEnable && (rsIdx < 8) && (rsPhase % 3 != 1);
            rsData  = 16'hA7 - 16'(rsIdx);
            rsPhase++;
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] src, input logic [2:0] dst,
                                 input logic [DW-1:0] data, input logic expErr, input logic [DW-1:0] expData,
                                 input int lat, input bit push);
        bit ok = 1'b0;
        cmdOp = op; cmdSrc = src; cmdDst = dst; cmdData = data; cmdValid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            if (cmdReady) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            failNow("cmd_accept");
        end else begin
            @(posedge clk); #1;
            if (push) begin
                expTab[expTail] = '{expErr, expData, (lat < 0) ? -1 : cyc + lat};
                expTail++;
            end
        end
        cmdValid = 1'b0; cmdOp = 3'b111; cmdSrc = ~src; cmdDst = ~dst; cmdData = 16'hDEAD;
    endtask

    task automatic waitDone(input string name);
        bit done = 1'b0;
        for (int t = 0; t < 600; t++) begin
            if (expHead == expTail && !busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) failNow(name);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_cmd_ready"}, {31'd0, cmdReady}, 0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
        checkOutput({tag, "_rsp_valid"}, {31'd0, rspValid}, 0);
        checkOutput({tag, "_rsp_err"}, {31'd0, rspErr}, 0);
        checkOutput({tag, "_rsp_data"}, {16'd0, rspData}, 0);
        checkOutput({tag, "_sv_valid"}, {31'd0, svValid}, 0);
        checkOutput({tag, "_sv_data"}, {16'd0, svData}, 0);
        checkOutput({tag, "_rs_ready"}, {31'd0, rsReady}, 0);
        checkOutput({tag, "_rb_id"}, {29'd0, rbId}, 0);
        checkOutput({tag, "_rb_din"}, {16'd0, rbDin}, 0);
        checkOutput({tag, "_rb_ld"}, {31'd0, rbLd}, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ld0;
        int sv0;
        bit reached;
        rstN = 1'b0; cmdValid = 1'b0; cmdOp = '0; cmdSrc = '0; cmdDst = '0; cmdData = '0;
        mRsp = '0;
        for (int k = 0; k < 8; k++) mBank[k] = '0;
        repeat (3) @(posedge clk); #1;
        checkIdleOutputs("reset");
        @(posedge clk); #1;
        rstN = 1'b1;
        #1;
        checkOutput("ready_after_reset", {31'd0, cmdReady}, 1);

        ld0 = ldCount;
        applyStimulus(OP_WRITE, 3'd0, 3'd5, 16'hBEEF, 1'b0, mRsp, 1, 1'b1);
        mBank[5] = 16'hBEEF;
        waitDone("write5_done");
        checkOutput("write5_ld_pulses", ldCount - ld0, 1);
        checkOutput("write5_ld_id", {29'd0, lastId}, 5);
        checkOutput("write5_ld_din", {16'd0, lastDin}, 16'hBEEF);

        ld0 = ldCount;
        mRsp = 16'hBEEF;
        applyStimulus(OP_READ, 3'd5, 3'd0, 16'h0, 1'b0, mRsp, 1, 1'b1);
        waitDone("read5_done");
        checkOutput("read5_no_ld", ldCount - ld0, 0);

        for (int n = 0; n < 8; n++) begin
            applyStimulus(OP_WRITE, 3'd0, 3'(n), 16'h1000 + 16'(n), 1'b0, mRsp, 1, 1'b1);
            mBank[n] = 16'h1000 + 16'(n);
        end
        waitDone("preload_done");

        ld0 = ldCount;
        applyStimulus(OP_MOVE, 3'd2, 3'd6, 16'h5555, 1'b0, mRsp, 2, 1'b1);
        mBank[6] = mBank[2];
        waitDone("move_done");
        checkOutput("move_r6", {16'd0, bank[6]}, 16'h1002);
        checkOutput("move_ld_pulses", ldCount - ld0, 1);
        checkOutput("move_ld_id", {29'd0, lastId}, 6);

        applyStimulus(OP_WRITE, 3'd0, 3'd6, 16'h1006, 1'b0, mRsp, 1, 1'b1);
        mBank[6] = 16'h1006;
        applyStimulus(OP_NOP, 3'd0, 3'd0, 16'h0, 1'b0, mRsp, 0, 1'b1);
        mRsp = 16'h1006;
        applyStimulus(OP_READ, 3'd6, 3'd0, 16'h0, 1'b0, mRsp, 1, 1'b1);
        waitDone("readback_done");

        svMode = 1;
        sv0 = svTotal;
        applyStimulus(OP_SAVE, 3'd0, 3'd0, 16'h0, 1'b0, mRsp, -1, 1'b1);
        waitDone("save_done");
        checkOutput("save_word_count", svTotal - sv0, 8);
        svMode = 0;

        ld0 = ldCount;
        rsEnable = 1'b1;
        applyStimulus(OP_RESTORE, 3'd0, 3'd0, 16'h0, 1'b0, mRsp, -1, 1'b1);
        waitDone("restore_done");
        rsEnable = 1'b0;
        checkOutput("restore_ld_pulses", ldCount - ld0, ZERO ? 7 : 8);
        for (int k = 0; k < 8; k++) mBank[k] = 16'h00A0 + 16'(k);
        for (int k = 1; k < 8; k++) checkOutput("restore_bank", {16'd0, bank[k]}, 32'h00A0 + k);
`ifndef RXC_ZERO_REG_EN
        checkOutput("restore_bank_r0", {16'd0, bank[0]}, 32'h00A0);
`endif

        ld0 = ldCount;
        applyStimulus(3'b111, 3'd1, 3'd2, 16'h0, 1'b1, mRsp, 0, 1'b1);
        applyStimulus(3'b110, 3'd3, 3'd4, 16'h0, 1'b1, mRsp, 0, 1'b1);
        waitDone("illegal_done");
        checkOutput("illegal_no_ld", ldCount - ld0, 0);

        ld0 = ldCount;
`ifdef RXC_ZERO_REG_EN
        applyStimulus(OP_WRITE, 3'd0, 3'd0, 16'h1234, 1'b0, mRsp, 1, 1'b1);
        mRsp = 16'h0000;
        applyStimulus(OP_READ, 3'd0, 3'd0, 16'h0, 1'b0, mRsp, 1, 1'b1);
        waitDone("zero_reg_done");
        checkOutput("zero_reg_no_ld", ldCount - ld0, 0);
`else
        applyStimulus(OP_WRITE, 3'd0, 3'd0, 16'h1234, 1'b0, mRsp, 1, 1'b1);
        mBank[0] = 16'h1234;
        mRsp = 16'h1234;
        applyStimulus(OP_READ, 3'd0, 3'd0, 16'h0, 1'b0, mRsp, 1, 1'b1);
        waitDone("r0_plain_done");
        checkOutput("r0_plain_ld", ldCount - ld0, 1);
`endif

        // SAVE aborted by reset while word 3 is stalled on the stream.
        svMode = 0;
        applyStimulus(OP_SAVE, 3'd0, 3'd0, 16'h0, 1'b0, mRsp, -1, 1'b0);
        reached = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (svIdx == 3) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!reached) failNow("save_reach_i3");
        svMode = 2;
        repeat (2) @(posedge clk); #1;
        checkOutput("abort_sv_valid", {31'd0, svValid}, 1);
        checkOutput("abort_rb_id", {29'd0, rbId}, 3);
        rstN = 1'b0;
        #1;
        checkIdleOutputs("abort");
        repeat (3) @(posedge clk); #1;
        rstN = 1'b1;
        mRsp = '0;
        #1;
        checkOutput("abort_ready", {31'd0, cmdReady}, 1);
        checkOutput("abort_busy", {31'd0, busy}, 0);
        svMode = 0;

        applyStimulus(OP_NOP, 3'd0, 3'd0, 16'h0, 1'b0, mRsp, 0, 1'b1);
        mRsp = 16'h00A1;
        applyStimulus(OP_READ, 3'd1, 3'd0, 16'h0, 1'b0, mRsp, 1, 1'b1);
        waitDone("final_done");
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
- Initiator side of the 8x16 register-bank port. Drives bank id/data/load and samples bank read data on behalf of the control unit.
- Executes single-register READ/WRITE/MOVE commands and whole-bank SAVE (r0..r7 out to a stream) and RESTORE (stream in to r7..r0), for context spill/fill to the stack.
- Sits between the control unit (command/response) and the register bank (rb_* pins).

Parameters:
- DW, 16, data width (matches bank register width)
- NREG, 8, registers in bank; id width is clog2(NREG)=3

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  3  000 NOP, 001 READ, 010 WRITE, 011 MOVE, 100 SAVE, 101 RESTORE, 11x illegal
- cmd_src  in  3  source register id
- cmd_dst  in  3  destination register id
- cmd_data  in  DW  WRITE data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  valid with rsp_valid; 1 = illegal op
- rsp_data  out  DW  READ result; held until next READ completes
- busy  out  1  state != IDLE
- sv_valid / sv_ready  out / in  1 / 1  SAVE stream handshake
- sv_data  out  DW  SAVE word
- rs_valid / rs_ready  in / out  1 / 1  RESTORE stream handshake
- rs_data  in  DW  RESTORE word
- rb_id  out  3  to bank rId
- rb_din  out  DW  to bank rIn
- rb_ld  out  1  to bank ldR
- rb_dout  in  DW  from bank rOut (combinational on rb_id)

Behaviour:
- Reset (async, reset=0): state IDLE; rb_ld=0, rb_id=0, rb_din=0, rsp_valid=0, rsp_err=0, rsp_data=0, sv_valid=0, sv_data=0, rs_ready=0, busy=0, cmd_ready=0 while reset is asserted. Reset mid-operation aborts the operation with no rsp_valid. Partial SAVE/RESTORE effects are not undone.
- All rb_* outputs are registered. rb_id and rb_din are stable for the whole cycle in which rb_ld=1. rb_ld is high for exactly one cycle per bank write, because the bank gates its load with clk.
- Accept: cmd_valid & cmd_ready at edge E0.
- NOP: rsp_valid in the cycle after E0.
- READ: cycle after E0 state RD, rb_id=src. E1 latches rb_dout into rsp_data. rsp_valid in the cycle after E1, which is also IDLE (cmd_ready=1), so back-to-back commands are allowed.
- WRITE: cycle after E0 state WR, rb_id=dst, rb_din=cmd_data, rb_ld=1. rsp_valid in the cycle after E1.
- MOVE: RD(src) cycle; E1 latches rb_dout into rb_din; WR(dst) cycle with rb_ld=1; rsp_valid after E2. src==dst is legal and rewrites the same value. rsp_data is unchanged by MOVE.
- SAVE: counter i=0..7.
  - SV_RD: rb_id=i.
  - Next edge: sv_data=rb_dout, sv_valid=1 (state SV_OUT).
  - Hold sv_data/sv_valid until sv_valid & sv_ready, then i++ and go to SV_RD.
  - After the i=7 handshake: rsp_valid, IDLE.
  - 8 words emitted, r0 first.
- RESTORE: counter i=7..0.
  - RS_WAIT: rs_ready=1.
  - On rs_valid & rs_ready: rb_din=rs_data, rb_id=i, rb_ld=1 next cycle (state RS_WR, rs_ready=0), then i-- and return to RS_WAIT.
  - After the r0 write: rsp_valid, IDLE.
  - First word is written to r7, so SAVE followed by a stack pop order round-trips.
- Illegal op (110, 111): rsp_valid=1, rsp_err=1 in the cycle after E0. No bank access.
- rsp_err is 0 on every other completion.
- cmd inputs are sampled only at accept. Later changes are ignored.

Optional Feature:
- Macro RXC_ZERO_REG_EN.
- Defined: r0 is treated as a hardwired zero.
  - READ/MOVE source 0 yields 0x0000 regardless of rb_dout.
  - WRITE/MOVE to dst 0 keeps rb_ld=0 with unchanged latency.
  - SAVE emits 0x0000 for r0.
  - RESTORE consumes the r0 word but does not assert rb_ld.
- Undefined: r0 behaves as an ordinary register.

Test Plan:
- Reset release, WRITE dst=5 data=0xBEEF, then READ src=5 -> rb_ld one cycle with rb_id=5; READ rsp_valid 2 cycles after accept with rsp_data=0xBEEF, rsp_err=0.
- Bank preloaded rN=0x1000+N; MOVE src=2 dst=6 -> r6=0x1002, rsp_valid 3 cycles after accept, rsp_data unchanged.
- SAVE with sv_ready toggling 1,0,0,1... -> 8 words 0x1000..0x1007 in order, sv_data held while stalled, single rsp_valid after the 8th handshake.
- RESTORE of stream 0xA7,0xA6,...,0xA0 with rs_valid gaps -> rK=0xA0+K, exactly 8 rb_ld pulses, rsp_valid after the r0 write.
- cmd_op=111, then reset asserted during SAVE at i=3 -> rsp_err=1 pulse with no rb_ld; after reset, all outputs zero, IDLE, no rsp_valid.
- With RXC_ZERO_REG_EN: WRITE dst=0 data=0x1234 then READ src=0 -> no rb_ld, rsp_data=0x0000.
